// File: rtl/abejaruco_exec_pkg.sv
// Shared execution-unit definitions: divider FSM state encoding and default width.
package abejaruco_exec_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE   = 2'd0;
  localparam div_state_t DIV_DIVIDE = 2'd1;
  localparam div_state_t DIV_FINISH = 2'd2;

  localparam int DIVIDER_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in one dividend bit, compare with divisor, subtract if it fits.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted value needs WIDTH+1 bits: with a divisor >= 2^(WIDTH-1) the
  // partial remainder can have its MSB set before the shift.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff_lo;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction is taken the true result is below divisor, so the low bits are exact.
  assign diff_lo = shifted[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? diff_lo : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Optional signed operation when DIVIDER_SIGNED_EN is defined (adds port is_signed).
module divider
  import abejaruco_exec_pkg::*;
#(
  parameter int WIDTH       = DIVIDER_DEFAULT_WIDTH,
  parameter int COUNT_WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_division,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             division_by_zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       debug_state
);

  // Handshake: a start_division pulse is accepted only on an edge where the
  // FSM is IDLE; done pulses for one cycle when results change, and results
  // hold until the next accepted start. No backpressure exists.

  div_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]       dvd_q, dvd_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic [WIDTH-1:0]       prem_q, prem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic                   zero_q, zero_d;
  logic                   neg_q_q, neg_q_d;
  logic                   neg_r_q, neg_r_d;
  logic [WIDTH-1:0]       q_out_q, q_out_d;
  logic [WIDTH-1:0]       r_out_q, r_out_d;
  logic                   dbz_q, dbz_d;
  logic                   done_q, done_d;

  logic                   dvd_neg, dvs_neg;
  logic [WIDTH-1:0]       dvd_mag, dvs_mag;
  logic [WIDTH-1:0]       step_rem;
  logic                   step_bit;

`ifdef DIVIDER_SIGNED_EN
  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
`endif

  // The unsigned core always sees magnitudes; the most-negative value maps to itself, which is correct unsigned.
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (prem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    zero_d  = zero_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start_division) begin
          dbz_d   = 1'b0;
          zero_d  = (divisor == '0);
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          neg_q_d = dvd_neg ^ dvs_neg;
          neg_r_d = dvd_neg;
          count_d = COUNT_WIDTH'(WIDTH);
          quo_d   = '0;
          prem_d  = '0;
          if (divisor == '0) begin
            quo_d   = '1;
            prem_d  = dividend;
            state_d = DIV_FINISH;
          end else begin
            state_d = DIV_DIVIDE;
          end
        end
      end
      DIV_DIVIDE: begin
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        prem_d  = step_rem;
        quo_d   = {quo_q[WIDTH-2:0], step_bit};
        count_d = count_q - 1'b1;
        if (count_q == COUNT_WIDTH'(1)) begin
          state_d = DIV_FINISH;
        end
      end
      DIV_FINISH: begin
        done_d  = 1'b1;
        dbz_d   = zero_q;
        // Divide-by-zero results are already in final form and skip the sign fix-up.
        q_out_d = (!zero_q && neg_q_q) ? -quo_q  : quo_q;
        r_out_d = (!zero_q && neg_r_q) ? -prem_q : prem_q;
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      zero_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      zero_q  <= zero_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign quotient         = q_out_q;
  assign remainder        = r_out_q;
  assign division_by_zero = dbz_q;
  assign busy             = (state_q == DIV_DIVIDE);
  assign done             = done_q;
  assign debug_state      = state_q;

endmodule
